dwrr_flow_scheduler: RTL and testbench
======================================

Name: dwrr_flow_scheduler

Overview:
- Consumer side of the per-flow DWRR credit store.
- Scans flows round-robin and queries each flow's credit through the store's flow_check / flow_credit_value read port.
- Grants one packet at a time to the datapath, emits consume_credit pulses, and forwards end-of-packet as packet_tlast to trigger credit replenishment.
- Sits between the per-flow queue status and the multichannel buffer read datapath.

Parameters:
- FLOW_W, 3, flow index width; flows 0..2**FLOW_W-1.
- MAX_CREDIT_W, 3, width of the credit value returned by the store.
- CREDIT_LAT, 2, cycles from flow_check change to a valid flow_credit_value (≥1).
- BURST_MAX, 4, maximum consecutive packets granted to one flow per visit (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- credit_init_done  in  1  credit store initialised; no scheduling before this is high
- flow_nonempty  in  2**FLOW_W  bit n = queue of flow n holds at least one full packet
- flow_check  out  FLOW_W  flow whose credit is queried (= ptr register)
- flow_credit_value  in  MAX_CREDIT_W  credit of flow_check, CREDIT_LAT cycles late
- consume_credit_valid  out  1  one-cycle pulse: one credit used
- consume_credit_flow  out  FLOW_W  flow charged; valid with pulse
- grant_valid  out  1  packet grant offered to datapath
- grant_flow  out  FLOW_W  granted flow
- grant_ready  in  1  datapath accepts grant
- dp_beat_valid  in  1  datapath transferred one beat of granted packet
- dp_beat_last  in  1  qualifies dp_beat_valid: last beat
- packet_tlast  out  1  one-cycle registered pulse on packet end, to credit store
- protocol_err  out  1  sticky: beat seen outside XFER

Behaviour:
- Reset (rst=1 at clk edge) sets state WAIT_INIT, ptr=0, wait_cnt=0, burst_cnt=0, and drives all outputs to 0, including protocol_err. The effect is visible the cycle after the edge. Reset mid-grant or mid-packet drops grant_valid with no consume or tlast pulse.
- State transitions:
  - WAIT_INIT -> SCAN when credit_init_done=1.
  - SCAN:
    - all flow_nonempty=0 -> hold.
    - flow_nonempty[ptr]=0 -> ptr++ (wraps 2**FLOW_W-1 -> 0), burst_cnt=0, stay. This skips one empty flow per cycle.
    - else -> WAIT_CRED, wait_cnt=0.
  - WAIT_CRED: wait_cnt increments. At wait_cnt==CREDIT_LAT-1, sample flow_credit_value next edge.
    - credit!=0 and flow_nonempty[ptr]=1 -> GRANT.
    - otherwise -> SCAN with ptr++, burst_cnt=0.
  - GRANT: grant_valid=1, grant_flow=ptr, held stable until grant_ready.
    - On grant_valid&&grant_ready, consume_credit_valid pulses next cycle with consume_credit_flow=ptr, burst_cnt++, -> XFER.
  - XFER: on dp_beat_valid&&dp_beat_last, packet_tlast pulses next cycle.
    - burst_cnt==BURST_MAX -> SCAN, ptr++, burst_cnt=0.
    - else -> SCAN, same ptr. This re-queries the credit so the decrement is seen.
- Latency: SCAN cycle t with nonempty flow -> grant_valid high at t+CREDIT_LAT+1.
- Zero credit:
  - Zero credit is never granted.
  - Credit arithmetic is owned by the store; the scheduler only tests for nonzero.
- Exactly one consume pulse per accepted grant and one packet_tlast per packet end. The two pulses never occur in the same cycle.
- dp_beat_valid outside XFER sets protocol_err. That beat is otherwise ignored.
- Single-beat packet: a last beat in the first XFER cycle is legal.
- credit_init_done falling while not in WAIT_INIT is ignored; only rst returns to WAIT_INIT.

Decomposition:
- Package dwrr_pkg: state enum (WAIT_INIT, SCAN, WAIT_CRED, GRANT, XFER) and a function next_flow(ptr) implementing wrap-around.
- Package constants shared with the credit store: FLOW_W and MAX_CREDIT_W defaults.
- No sub-module needed. The optional shared credit-store read-latency model for benches is named dwrr_credit_model.

Test Plan:
- Hold credit_init_done=0 for 40 cycles with flow_nonempty=8'hFF -> grant_valid stays 0. Then assert it -> first grant_flow=0 at SCAN+3 cycles (CREDIT_LAT=2).
- flow_nonempty=8'b0010_0001, model credits 3 for all flows, 1-beat packets, grant_ready=1 -> grants: flow0 ×3 (credit-limited), then flow5 ×3, then flow0 again. Each grant is followed by one consume pulse with the matching flow and one packet_tlast.
- Flow 2 credit=0, flows 2 and 3 nonempty -> flow 2 is never granted and no consume pulse carries flow=2. Flow 3 is granted.
- Model grants +1 credit per packet_tlast to the served flow (credit never drops), flow 1 only nonempty, BURST_MAX=4 -> after 4 grants ptr advances, scans flows 2..7 and 0, returns to flow 1. Grants continue indefinitely with no more than 4 back-to-back.
- grant_ready held low 10 cycles -> grant_valid and grant_flow stable throughout, and no consume pulse until the accept cycle+1.
- rst asserted mid-XFER of a 5-beat packet -> next cycle all outputs 0, no packet_tlast. Then dp_beat_valid without a grant -> protocol_err=1 and it stays 1 until rst.

Source files
------------

// File: rtl/dwrr_pkg.sv
// Shared types and constants for the DWRR flow scheduler and its credit store.
package dwrr_pkg;

  // Defaults shared with the per-flow credit store
  localparam int FLOW_W_DEF       = 3;
  localparam int MAX_CREDIT_W_DEF = 3;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    SCAN      = 3'd1,
    WAIT_CRED = 3'd2,
    GRANT     = 3'd3,
    XFER      = 3'd4
  } state_t;

  // Round-robin successor of a flow index, wrapping at num_flows-1
  function automatic logic [31:0] next_flow(input logic [31:0] ptr,
                                            input logic [31:0] num_flows);
    return (ptr >= num_flows - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/dwrr_flow_scheduler.sv
// Consumer side of the per-flow DWRR credit store: scans flows round-robin,
// checks each nonempty flow's credit, grants one packet at a time and reports
// credit consumption and packet end back to the store.
module dwrr_flow_scheduler
  import dwrr_pkg::*;
#(
  parameter int FLOW_W       = FLOW_W_DEF,
  parameter int MAX_CREDIT_W = MAX_CREDIT_W_DEF,
  parameter int CREDIT_LAT   = 2,
  parameter int BURST_MAX    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    credit_init_done,
  input  logic [2**FLOW_W-1:0]    flow_nonempty,
  output logic [FLOW_W-1:0]       flow_check,
  input  logic [MAX_CREDIT_W-1:0] flow_credit_value,
  output logic                    consume_credit_valid,
  output logic [FLOW_W-1:0]       consume_credit_flow,
  output logic                    grant_valid,
  output logic [FLOW_W-1:0]       grant_flow,
  input  logic                    grant_ready,
  input  logic                    dp_beat_valid,
  input  logic                    dp_beat_last,
  output logic                    packet_tlast,
  output logic                    protocol_err
);

  localparam int NUM_FLOWS = 2**FLOW_W;
  localparam int WAIT_W    = $clog2(CREDIT_LAT) + 1;
  localparam int BURST_W   = $clog2(BURST_MAX + 1);

  state_t              state, state_nxt;
  logic [FLOW_W-1:0]   ptr, ptr_nxt, ptr_adv;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic [BURST_W-1:0]  burst_cnt, burst_nxt;
  logic                accept;
  logic                pkt_end;

  assign ptr_adv    = FLOW_W'(next_flow(32'(ptr), 32'(NUM_FLOWS)));
  assign accept     = (state == GRANT) && grant_ready;
  assign pkt_end    = (state == XFER) && dp_beat_valid && dp_beat_last;
  assign flow_check = ptr;

  // State, pointer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_INIT;
      ptr       <= '0;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Next-state logic: scan, credit wait, grant handshake, transfer
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    case (state)
      WAIT_INIT: begin
        if (credit_init_done) state_nxt = SCAN;
      end
      SCAN: begin
        // Nothing queued anywhere: park on the current flow
        if (|flow_nonempty) begin
          if (!flow_nonempty[ptr]) begin
            ptr_nxt   = ptr_adv;
            burst_nxt = '0;
          end else begin
            state_nxt = WAIT_CRED;
            wait_nxt  = '0;
          end
        end
      end
      WAIT_CRED: begin
        // flow_check has been stable long enough for the store's read port
        if (wait_cnt == WAIT_W'(CREDIT_LAT - 1)) begin
          if ((flow_credit_value != '0) && flow_nonempty[ptr]) begin
            state_nxt = GRANT;
          end else begin
            state_nxt = SCAN;
            ptr_nxt   = ptr_adv;
            burst_nxt = '0;
          end
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      GRANT: begin
        if (grant_ready) begin
          state_nxt = XFER;
          burst_nxt = burst_cnt + BURST_W'(1);
        end
      end
      XFER: begin
        // Stay on the flow and re-query so the store's decrement is observed,
        // unless this visit has used up its burst allowance
        if (dp_beat_valid && dp_beat_last) begin
          state_nxt = SCAN;
          if (burst_cnt == BURST_W'(BURST_MAX)) begin
            ptr_nxt   = ptr_adv;
            burst_nxt = '0;
          end
        end
      end
      default: state_nxt = WAIT_INIT;
    endcase
  end

  // Grant outputs decoded from state
  always_comb begin
    grant_valid = (state == GRANT);
    grant_flow  = (state == GRANT) ? ptr : '0;
  end

  // Registered one-cycle pulses toward the credit store
  always_ff @(posedge clk) begin
    if (rst) begin
      consume_credit_valid <= 1'b0;
      consume_credit_flow  <= '0;
      packet_tlast         <= 1'b0;
    end else begin
      consume_credit_valid <= accept;
      consume_credit_flow  <= accept ? ptr : '0;
      packet_tlast         <= pkt_end;
    end
  end

  // Sticky flag for datapath beats that arrive with no packet in flight
  always_ff @(posedge clk) begin
    if (rst)                                 protocol_err <= 1'b0;
    else if (dp_beat_valid && state != XFER) protocol_err <= 1'b1;
  end

endmodule

// File: tb/tb_dwrr_flow_scheduler.sv
// Self-checking bench for dwrr_flow_scheduler: credit store with read latency,
// transaction-level round-robin/burst reference model, directed and random runs.
module tb_dwrr_flow_scheduler;

  localparam int FLOW_W       = 3;
  localparam int MAX_CREDIT_W = 3;
  localparam int CREDIT_LAT   = 2;
  localparam int BURST_MAX    = 4;
  localparam int NF           = 2**FLOW_W;

  logic                    clk;
  logic                    rst;
  logic                    credit_init_done;
  logic [NF-1:0]           flow_nonempty;
  logic [FLOW_W-1:0]       flow_check;
  logic [MAX_CREDIT_W-1:0] flow_credit_value;
  logic                    consume_credit_valid;
  logic [FLOW_W-1:0]       consume_credit_flow;
  logic                    grant_valid;
  logic [FLOW_W-1:0]       grant_flow;
  logic                    grant_ready;
  logic                    dp_beat_valid;
  logic                    dp_beat_last;
  logic                    packet_tlast;
  logic                    protocol_err;

  int checks = 0;
  int errors = 0;

  dwrr_flow_scheduler #(
    .FLOW_W(FLOW_W), .MAX_CREDIT_W(MAX_CREDIT_W),
    .CREDIT_LAT(CREDIT_LAT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst), .credit_init_done(credit_init_done),
    .flow_nonempty(flow_nonempty), .flow_check(flow_check),
    .flow_credit_value(flow_credit_value),
    .consume_credit_valid(consume_credit_valid),
    .consume_credit_flow(consume_credit_flow),
    .grant_valid(grant_valid), .grant_flow(grant_flow),
    .grant_ready(grant_ready), .dp_beat_valid(dp_beat_valid),
    .dp_beat_last(dp_beat_last), .packet_tlast(packet_tlast),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- credit store environment ----------------
  logic [MAX_CREDIT_W-1:0] cred     [NF];
  logic [MAX_CREDIT_W-1:0] load_val [NF];
  logic [MAX_CREDIT_W-1:0] cpipe    [CREDIT_LAT];
  logic                    load_req;
  logic                    repl;
  logic [FLOW_W-1:0]       last_flow;

  assign flow_credit_value = cpipe[CREDIT_LAT-1];

  // Store: read port delayed CREDIT_LAT cycles, -1 per consume, optional +1 per packet end
  always @(posedge clk) begin
    cpipe[0] <= cred[flow_check];
    for (int i = 1; i < CREDIT_LAT; i++) cpipe[i] <= cpipe[i-1];
    if (consume_credit_valid) last_flow <= consume_credit_flow;
    if (load_req) begin
      for (int i = 0; i < NF; i++) cred[i] <= load_val[i];
    end else begin
      if (consume_credit_valid && cred[consume_credit_flow] != '0)
        cred[consume_credit_flow] <= cred[consume_credit_flow] - 1'b1;
      if (packet_tlast && repl && cred[last_flow] != '1)
        cred[last_flow] <= cred[last_flow] + 1'b1;
    end
  end

  // ---------------- reference model (transaction level) ----------------
  int     m_ptr, m_burst;
  int     m_cred [NF];
  logic [NF-1:0] m_mask;
  bit     m_repl;
  bit     m_done;
  int     n_f2;

  // Next granted flow under round-robin with per-visit burst cap; -1 if none eligible
  function automatic int model_next(output int ptr_after);
    for (int s = 0; s < 2*NF; s++) begin
      if (m_mask[m_ptr] && m_cred[m_ptr] > 0) begin
        int f;
        f = m_ptr;
        if (!m_repl) m_cred[f] = m_cred[f] - 1;
        m_burst++;
        if (m_burst == BURST_MAX) begin
          m_ptr   = (m_ptr + 1) % NF;
          m_burst = 0;
        end
        ptr_after = m_ptr;
        return f;
      end
      m_ptr   = (m_ptr + 1) % NF;
      m_burst = 0;
    end
    ptr_after = m_ptr;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse-level invariants watched continuously
  always @(negedge clk) begin
    if (!rst && consume_credit_valid) begin
      check("zero_credit_grant", 32'(cred[consume_credit_flow] != '0), 32'd1);
      check("pulse_overlap", 32'(packet_tlast), 32'd0);
      if (consume_credit_flow == 3'd2) n_f2++;
    end
  end

  task automatic set_credits(input int c [NF]);
    for (int i = 0; i < NF; i++) begin
      load_val[i] = MAX_CREDIT_W'(c[i]);
      m_cred[i]   = c[i];
    end
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; grant_ready = 1'b0; dp_beat_valid = 1'b0; dp_beat_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_burst = 0;
  endtask

  // Wait for one grant, accept it after dly cycles, move an nbeats packet
  task automatic serve(input int f, input int pa, input int nbeats, input int dly);
    int cnt;
    cnt = 0;
    while (grant_valid !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("grant_seen", 32'(grant_valid), 32'd1);
    if (grant_valid !== 1'b1) return;
    check("grant_flow", 32'(grant_flow), 32'(f));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("grant_hold", 32'({grant_valid, grant_flow}), 32'({1'b1, 3'(f)}));
      check("no_early_consume", 32'(consume_credit_valid), 32'd0);
    end
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    check("consume_pulse", 32'(consume_credit_valid), 32'd1);
    check("consume_flow", 32'(consume_credit_flow), 32'(f));
    check("grant_dropped", 32'(grant_valid), 32'd0);
    for (int b = 0; b < nbeats; b++) begin
      dp_beat_valid = 1'b1;
      dp_beat_last  = (b == nbeats - 1);
      @(negedge clk);
      if (b == 0) check("consume_single", 32'(consume_credit_valid), 32'd0);
      if (b < nbeats - 1) check("tlast_early", 32'(packet_tlast), 32'd0);
    end
    dp_beat_valid = 1'b0;
    dp_beat_last  = 1'b0;
    check("tlast_pulse", 32'(packet_tlast), 32'd1);
    check("ptr_after_pkt", 32'(flow_check), 32'(pa));
  endtask

  task automatic run_model(input int n, input int max_beats, input int max_dly);
    int f, pa;
    m_done = 0;
    for (int k = 0; k < n; k++) begin
      f = model_next(pa);
      if (f < 0) begin
        m_done = 1;
        break;
      end
      serve(f, pa, $urandom_range(1, max_beats), $urandom_range(0, max_dly));
    end
    check("no_protocol_err", 32'(protocol_err), 32'd0);
  endtask

  task automatic dead_check(input int ncyc);
    bit seen;
    seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (grant_valid) seen = 1;
    end
    check("no_grant_without_credit", 32'(seen), 32'd0);
  endtask

  int cr [NF];

  initial begin
    rst = 1'b1; credit_init_done = 1'b0; flow_nonempty = '0;
    grant_ready = 1'b0; dp_beat_valid = 1'b0; dp_beat_last = 1'b0;
    repl = 1'b0; m_repl = 0; n_f2 = 0; load_req = 1'b0;
    for (int i = 0; i < NF; i++) cr[i] = 3;
    set_credits(cr);
    do_reset();
    check("reset_outputs",
          32'({grant_valid, grant_flow, consume_credit_valid, consume_credit_flow,
               packet_tlast, protocol_err, flow_check}), 32'd0);

    // Init gating, first-grant latency, then credit-limited service
    begin
      bit seen;
      seen = 0;
      flow_nonempty = 8'hFF;
      repeat (40) begin
        @(negedge clk);
        if (grant_valid || consume_credit_valid) seen = 1;
      end
      check("no_grant_before_init", 32'(seen), 32'd0);
      credit_init_done = 1'b1;
      repeat (3) @(negedge clk);
      check("grant_not_before_lat", 32'(grant_valid), 32'd0);
      @(negedge clk);
      check("grant_at_lat", 32'(grant_valid), 32'd1);
      check("first_grant_flow", 32'(grant_flow), 32'd0);
      m_mask = 8'hFF;
      run_model(6, 1, 0);
    end

    // Two nonempty flows, credit 3 each, single-beat packets; refill flow 0 later
    do_reset();
    set_credits(cr);
    flow_nonempty = 8'b0010_0001; m_mask = 8'b0010_0001;
    run_model(8, 1, 0);
    check("exhausted_after_6", 32'(m_done), 32'd1);
    dead_check(40);
    begin
      int c2 [NF];
      for (int i = 0; i < NF; i++) c2[i] = m_cred[i];
      c2[0] = 3;
      set_credits(c2);
    end
    run_model(1, 1, 0);

    // Zero-credit flow is never served
    do_reset();
    begin
      int c3 [NF];
      for (int i = 0; i < NF; i++) c3[i] = 3;
      c3[2] = 0;
      set_credits(c3);
    end
    n_f2 = 0;
    flow_nonempty = 8'b0000_1100; m_mask = 8'b0000_1100;
    run_model(5, 2, 1);
    dead_check(30);
    check("flow2_consumes", 32'(n_f2), 32'd0);

    // Replenish on packet end: burst cap forces a full lap between visits;
    // dropping credit_init_done after start has no effect
    do_reset();
    begin
      int c4 [NF];
      for (int i = 0; i < NF; i++) c4[i] = 0;
      c4[1] = 3;
      set_credits(c4);
    end
    repl = 1'b1; m_repl = 1;
    flow_nonempty = 8'b0000_0010; m_mask = 8'b0000_0010;
    run_model(1, 1, 0);
    credit_init_done = 1'b0;
    run_model(11, 1, 0);
    credit_init_done = 1'b1;
    repl = 1'b0; m_repl = 0;

    // Grant held 10 cycles against backpressure
    do_reset();
    set_credits(cr);
    flow_nonempty = 8'b0001_0000; m_mask = 8'b0001_0000;
    begin
      int f, pa;
      f = model_next(pa);
      serve(f, pa, 3, 10);
    end

    // Randomized masks, credits, packet lengths and ready delays
    for (int t = 0; t < 8; t++) begin
      int cx [NF];
      do_reset();
      for (int i = 0; i < NF; i++) cx[i] = $urandom_range(0, 4);
      set_credits(cx);
      m_mask = NF'($urandom_range(1, 255));
      flow_nonempty = m_mask;
      run_model(10, 4, 3);
      if (m_done) dead_check(30);
    end

    // Reset in the middle of a 5-beat packet, then a stray beat
    do_reset();
    set_credits(cr);
    flow_nonempty = 8'b0000_0001;
    begin
      int cnt;
      cnt = 0;
      while (grant_valid !== 1'b1 && cnt < 300) begin
        @(negedge clk);
        cnt++;
      end
      check("mid_rst_grant_seen", 32'(grant_valid), 32'd1);
    end
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    dp_beat_valid = 1'b1; dp_beat_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_xfer_outputs",
          32'({grant_valid, grant_flow, consume_credit_valid, consume_credit_flow,
               packet_tlast, protocol_err, flow_check}), 32'd0);
    rst = 1'b0; dp_beat_valid = 1'b0; flow_nonempty = '0;
    repeat (2) @(negedge clk);
    check("no_tlast_after_rst", 32'(packet_tlast), 32'd0);
    check("err_clear_after_rst", 32'(protocol_err), 32'd0);
    dp_beat_valid = 1'b1; dp_beat_last = 1'b1;
    @(negedge clk);
    dp_beat_valid = 1'b0; dp_beat_last = 1'b0;
    check("stray_beat_err", 32'(protocol_err), 32'd1);
    check("stray_beat_no_tlast", 32'(packet_tlast), 32'd0);
    repeat (10) @(negedge clk);
    check("err_sticky", 32'(protocol_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_cleared_by_rst", 32'(protocol_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
